// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus layouts, ALU op bit indices
// and divider state encodings.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 145;
    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int ALU_OP_WD       = 20;

    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_SLT   = 2;
    localparam int ALU_SLTU  = 3;
    localparam int ALU_AND   = 4;
    localparam int ALU_NOR   = 5;
    localparam int ALU_OR    = 6;
    localparam int ALU_XOR   = 7;
    localparam int ALU_SLL   = 8;
    localparam int ALU_SRL   = 9;
    localparam int ALU_SRA   = 10;
    localparam int ALU_LUI   = 11;
    localparam int ALU_MULT  = 12;
    localparam int ALU_MULTU = 13;
    localparam int ALU_MTHI  = 14;
    localparam int ALU_MTLO  = 15;
    localparam int ALU_MFHI  = 16;
    localparam int ALU_MFLO  = 17;
    localparam int ALU_DIV   = 18;
    localparam int ALU_DIVU  = 19;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Field order matches the decode stage packing, MSB first.
    typedef struct packed {
        logic [ALU_OP_WD-1:0] alu_op;
        logic                 load_op;
        logic                 src1_is_sa;
        logic                 src1_is_pc;
        logic                 src2_is_imm_0;
        logic                 src2_is_imm;
        logic                 src2_is_8;
        logic                 gr_we;
        logic                 mem_we;
        logic [4:0]           dest;
        logic [15:0]          imm;
        logic [31:0]          rs_value;
        logic [31:0]          rt_value;
        logic [31:0]          pc;
    } ds_to_es_t;

endpackage

// File: rtl/exe_stage_if.sv
// Pipeline-side signal bundle of the execute stage: decode handshake, memory
// handshake, forwarding info and the data-SRAM request.
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic                       ms_allowin;
    logic                       es_allowin;
    logic                       ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [4:0]                 es_to_ds_dest;
    logic                       es_valid_r;
    logic                       es_we_r;
    logic [31:0]                es_fw_send;
    logic                       es_send_ready;
    logic                       data_sram_en;
    logic [3:0]                 data_sram_wen;
    logic [31:0]                data_sram_addr;
    logic [31:0]                data_sram_wdata;

    modport slave (
        input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
        output es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_dest,
               es_valid_r, es_we_r, es_fw_send, es_send_ready,
               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport master (
        output ms_allowin, ds_to_es_valid, ds_to_es_bus,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_dest,
               es_valid_r, es_we_r, es_fw_send, es_send_ready,
               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

endinterface

// File: rtl/exe_stage_iter_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, sign fix-up applied combinationally once finished.
module iter_div
    import exe_stage_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        ack_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    localparam int CNT_W = $clog2(DIV_ITERS + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic             negq_q, negq_d, negr_q, negr_d;
    logic [31:0]      dividend_mag, divisor_mag;
    logic [32:0]      trial;

    assign dividend_mag = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
    assign divisor_mag  = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
    // Borrow out of bit 32 means the shifted remainder is below the divisor.
    assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            DIV_IDLE: if (start_i) begin
                state_d = DIV_BUSY;
                cnt_d   = '0;
                quo_d   = dividend_mag;
                rem_d   = 32'h0;
                dvs_d   = divisor_mag;
                negq_d  = signed_i && (dividend_i[31] ^ divisor_i[31]);
                negr_d  = signed_i && dividend_i[31];
            end
            DIV_BUSY: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = DIV_DONE;
            end
            DIV_DONE: if (ack_i) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= 32'h0;
            rem_q   <= 32'h0;
            dvs_q   <= 32'h0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign busy_o      = (state_q == DIV_BUSY);
    assign done_o      = (state_q == DIV_DONE);
    assign quotient_o  = negq_q ? -quo_q : quo_q;
    assign remainder_o = negr_q ? -rem_q : rem_q;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, single-cycle multiplier, HI/LO, iterative divider,
// data-SRAM request and forwarding info back to decode.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter logic [31:0] HILO_RST_VAL = 32'h0,
    parameter int          DIV_ITERS    = 32
) (
    input logic        clk,
    input logic        resetn,
    exe_stage_if.slave es_if
);

    ds_to_es_t   ds_q;
    logic        es_valid_q;
    logic [31:0] hi_q, lo_q;
    logic        es_ready_go, es_allowin_w, es_leave;
    logic        is_div, is_mul, res_from_mem;
    logic [31:0] src1, src2, es_result;
    logic [63:0] mul_a, mul_b, prod;
    logic        div_busy, div_done;
    logic [31:0] div_quo, div_rem;

    assign is_div       = ds_q.alu_op[ALU_DIV] | ds_q.alu_op[ALU_DIVU];
    assign is_mul       = ds_q.alu_op[ALU_MULT] | ds_q.alu_op[ALU_MULTU];
    assign es_ready_go  = !is_div || div_done;
    assign es_allowin_w = !es_valid_q || (es_ready_go && es_if.ms_allowin);
    assign es_leave     = es_valid_q && es_ready_go && es_if.ms_allowin;
    assign res_from_mem = ds_q.load_op && !ds_q.mem_we;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)           es_valid_q <= 1'b0;
        else if (es_allowin_w) es_valid_q <= es_if.ds_to_es_valid;
    end

    // Payload needs no reset: every consumer is qualified by es_valid_q.
    always_ff @(posedge clk) begin
        if (es_if.ds_to_es_valid && es_allowin_w) ds_q <= es_if.ds_to_es_bus;
    end

    always_comb begin
        src1 = ds_q.rs_value;
        if (ds_q.src1_is_sa)      src1 = {27'b0, ds_q.imm[10:6]};
        else if (ds_q.src1_is_pc) src1 = ds_q.pc;
        src2 = ds_q.rt_value;
        if (ds_q.src2_is_imm)        src2 = {{16{ds_q.imm[15]}}, ds_q.imm};
        else if (ds_q.src2_is_imm_0) src2 = {16'h0, ds_q.imm};
        else if (ds_q.src2_is_8)     src2 = 32'd8;
    end

    // One 64x64 multiplier serves both flavours; mult sign-extends its operands.
    assign mul_a = {{32{ds_q.alu_op[ALU_MULT] & ds_q.rs_value[31]}}, ds_q.rs_value};
    assign mul_b = {{32{ds_q.alu_op[ALU_MULT] & ds_q.rt_value[31]}}, ds_q.rt_value};
    assign prod  = mul_a * mul_b;

    always_comb begin
        es_result = 32'h0;
        case (1'b1)
            ds_q.alu_op[ALU_ADD]:  es_result = src1 + src2;
            ds_q.alu_op[ALU_SUB]:  es_result = src1 - src2;
            ds_q.alu_op[ALU_SLT]:  es_result = {31'b0, $signed(src1) < $signed(src2)};
            ds_q.alu_op[ALU_SLTU]: es_result = {31'b0, src1 < src2};
            ds_q.alu_op[ALU_AND]:  es_result = src1 & src2;
            ds_q.alu_op[ALU_NOR]:  es_result = ~(src1 | src2);
            ds_q.alu_op[ALU_OR]:   es_result = src1 | src2;
            ds_q.alu_op[ALU_XOR]:  es_result = src1 ^ src2;
            ds_q.alu_op[ALU_SLL]:  es_result = src2 << src1[4:0];
            ds_q.alu_op[ALU_SRL]:  es_result = src2 >> src1[4:0];
            ds_q.alu_op[ALU_SRA]:  es_result = 32'($signed(src2) >>> src1[4:0]);
            ds_q.alu_op[ALU_LUI]:  es_result = {ds_q.imm, 16'h0};
            ds_q.alu_op[ALU_MFHI]: es_result = hi_q;
            ds_q.alu_op[ALU_MFLO]: es_result = lo_q;
            default:               es_result = 32'h0;
        endcase
    end

    iter_div #(.DIV_ITERS(DIV_ITERS)) u_div (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (es_valid_q && is_div),
        .ack_i       (es_leave),
        .signed_i    (ds_q.alu_op[ALU_DIV]),
        .dividend_i  (ds_q.rs_value),
        .divisor_i   (ds_q.rt_value),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // Committing on departure guarantees a single write even under long stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= HILO_RST_VAL;
            lo_q <= HILO_RST_VAL;
        end else if (es_leave) begin
            if (is_mul) begin
                hi_q <= prod[63:32];
                lo_q <= prod[31:0];
            end else if (is_div) begin
                hi_q <= div_rem;
                lo_q <= div_quo;
            end else if (ds_q.alu_op[ALU_MTHI]) begin
                hi_q <= ds_q.rs_value;
            end else if (ds_q.alu_op[ALU_MTLO]) begin
                lo_q <= ds_q.rs_value;
            end
        end
    end

    assign es_if.es_allowin      = es_allowin_w;
    assign es_if.es_to_ms_valid  = es_valid_q && es_ready_go;
    assign es_if.es_to_ms_bus    = {res_from_mem, ds_q.gr_we, ds_q.dest, es_result, ds_q.pc};
    assign es_if.es_to_ds_dest   = ds_q.dest;
    assign es_if.es_valid_r      = es_valid_q;
    assign es_if.es_we_r         = ds_q.gr_we;
    assign es_if.es_fw_send      = es_result;
    assign es_if.es_send_ready   = es_valid_q && es_ready_go && !res_from_mem && !div_busy;
    assign es_if.data_sram_en    = es_valid_q && ds_q.load_op && es_if.ms_allowin;
    assign es_if.data_sram_wen   = es_if.data_sram_en ? {4{ds_q.mem_we}} : 4'h0;
    assign es_if.data_sram_addr  = es_result;
    assign es_if.data_sram_wdata = ds_q.rt_value;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vector table, hand-written stall/divide/reset
// sequences, and randomized instructions against an arithmetic reference model.
module tb_exe_stage;

    localparam int OP_ADD = 0, OP_SUB = 1, OP_SLT = 2, OP_SLTU = 3, OP_AND = 4,
                   OP_NOR = 5, OP_OR = 6, OP_XOR = 7, OP_SLL = 8, OP_SRL = 9,
                   OP_SRA = 10, OP_LUI = 11, OP_MULT = 12, OP_MULTU = 13,
                   OP_MTHI = 14, OP_MTLO = 15, OP_MFHI = 16, OP_MFLO = 17,
                   OP_DIV = 18, OP_DIVU = 19;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] m_hi, m_lo;

    exe_stage_if ifc ();

    exe_stage #(.HILO_RST_VAL(32'h0), .DIV_ITERS(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .es_if  (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // s1: 0 rs, 1 shamt, 2 pc.  s2: 0 rt, 1 sext imm, 2 zext imm, 3 eight.
    function automatic logic [144:0] mk(input int op, input int s1, input int s2,
                                        input logic ld, input logic mw, input logic we,
                                        input logic [4:0] dst, input logic [15:0] imm,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [31:0] pc);
        logic [19:0] oh;
        oh = '0;
        oh[op] = 1'b1;
        return {oh, ld, s1 == 1, s1 == 2, s2 == 2, s2 == 1, s2 == 3, we, mw, dst, imm, rs, rt, pc};
    endfunction

    function automatic logic [31:0] ref_src1(input int s1, input logic [15:0] imm,
                                             input logic [31:0] rs, input logic [31:0] pc);
        if (s1 == 1) return 32'(imm[10:6]);
        if (s1 == 2) return pc;
        return rs;
    endfunction

    function automatic logic [31:0] ref_src2(input int s2, input logic [15:0] imm, input logic [31:0] rt);
        if (s2 == 1) return 32'(int'($signed(imm)));
        if (s2 == 2) return 32'(imm);
        if (s2 == 3) return 32'd8;
        return rt;
    endfunction

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] imm);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_AND:  return a & b;
            OP_NOR:  return ~(a | b);
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return b << a[4:0];
            OP_SRL:  return b >> a[4:0];
            OP_SRA:  return 32'(int'(b) >>> a[4:0]);
            default: return {imm, 16'h0};
        endcase
    endfunction

    // Issue one instruction into an empty stage, randomly stall the memory
    // stage, and capture the bus on the cycle it is accepted downstream.
    task automatic run(input logic [144:0] b, input int stall, output logic [70:0] ob,
                       output logic sr, output logic [31:0] fw, output int wc, output logic ab);
        logic ok;
        ok = 1'b0; ab = 1'b0; wc = 0; ob = '0; sr = 1'b0; fw = '0;
        ifc.ds_to_es_valid = 1'b1;
        ifc.ds_to_es_bus   = b;
        ifc.ms_allowin     = 1'b1;
        @(posedge clk); #1;
        ifc.ds_to_es_valid = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            ifc.ms_allowin = ($urandom_range(99) >= stall);
            @(negedge clk);
            if (ifc.es_to_ms_valid) begin
                if (ifc.ms_allowin) begin
                    ok = 1'b1;
                    ob = ifc.es_to_ms_bus;
                    sr = ifc.es_send_ready;
                    fw = ifc.es_fw_send;
                end
            end else begin
                wc++;
                if (ifc.es_allowin) ab = 1'b1;
            end
            @(posedge clk); #1;
        end
        ifc.ms_allowin = 1'b1;
        check("retire", {31'b0, ok}, 32'd1);
    endtask

    // Model-checked instruction: ALU/mf* results, divide latency, HI/LO update.
    task automatic exec(input int op, input int s1, input int s2, input logic [15:0] imm,
                        input logic [31:0] rs, input logic [31:0] rt, input int stall,
                        output logic [31:0] res);
        logic [70:0] ob; logic sr, ab; logic [31:0] fw, pc; int wc;
        logic [63:0] p; longint q, r;
        pc = $urandom;
        run(mk(op, s1, s2, 1'b0, 1'b0, 1'b1, 5'd2, imm, rs, rt, pc), stall, ob, sr, fw, wc, ab);
        res = ob[63:32];
        if (op <= OP_LUI)
            check($sformatf("alu op%0d", op), res, ref_alu(op, ref_src1(s1, imm, rs, pc), ref_src2(s2, imm, rt), imm));
        else if (op == OP_MFHI) check("mfhi", res, m_hi);
        else if (op == OP_MFLO) check("mflo", res, m_lo);
        check($sformatf("busy cycles op%0d", op), 32'(wc), (op >= OP_DIV) ? 32'd33 : 32'd0);
        if (op >= OP_DIV) check("allowin low in div", {31'b0, ab}, 32'd0);
        case (op)
            OP_MULT:  begin p = 64'(longint'(int'(rs)) * longint'(int'(rt))); m_hi = p[63:32]; m_lo = p[31:0]; end
            OP_MULTU: begin p = {32'h0, rs} * {32'h0, rt}; m_hi = p[63:32]; m_lo = p[31:0]; end
            OP_MTHI:  m_hi = rs;
            OP_MTLO:  m_lo = rs;
            OP_DIV: begin
                if (rt == 0) begin m_lo = rs[31] ? 32'd1 : 32'hFFFFFFFF; m_hi = rs; end
                else begin
                    q = longint'(int'(rs)) / longint'(int'(rt));
                    r = longint'(int'(rs)) % longint'(int'(rt));
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            OP_DIVU: begin
                if (rt == 0) begin m_lo = 32'hFFFFFFFF; m_hi = rs; end
                else begin m_lo = rs / rt; m_hi = rs % rt; end
            end
            default: ;
        endcase
    endtask

    // Hold one instruction under ms_allowin = 0,0,1 then one idle cycle.
    task automatic stall_seq(input logic [144:0] b, output int hits, output int held);
        hits = 0; held = 0;
        ifc.ds_to_es_valid = 1'b1;
        ifc.ds_to_es_bus   = b;
        ifc.ms_allowin     = 1'b0;
        @(posedge clk); #1;
        ifc.ds_to_es_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifc.ms_allowin = (i >= 2);
            @(negedge clk);
            if (ifc.data_sram_wen == 4'hF && ifc.data_sram_wdata == 32'hDEADBEEF) hits++;
            if (ifc.es_valid_r) held++;
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        int op; int s1; int s2;
        logic [15:0] imm; logic [31:0] rs; logic [31:0] rt; logic [31:0] pc; logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t vt[14];
        logic [70:0] ob; logic sr, ab; logic [31:0] fw, res, rs, rt; int wc, hits, held, op, s1, s2;
        logic [15:0] imm;

        vt[0]  = '{OP_ADD,  0, 1, 16'hFFFF, 32'd5,        32'd0,        32'h100,      32'd4};
        vt[1]  = '{OP_SUB,  0, 0, 16'h0,    32'd3,        32'd5,        32'h104,      32'hFFFFFFFE};
        vt[2]  = '{OP_SLT,  0, 0, 16'h0,    32'hFFFFFFFF, 32'd1,        32'h108,      32'd1};
        vt[3]  = '{OP_SLTU, 0, 0, 16'h0,    32'hFFFFFFFF, 32'd1,        32'h10C,      32'd0};
        vt[4]  = '{OP_AND,  0, 0, 16'h0,    32'hF0F0F0F0, 32'hFF00FF00, 32'h110,      32'hF000F000};
        vt[5]  = '{OP_NOR,  0, 0, 16'h0,    32'hF0F0F0F0, 32'h0F0F0000, 32'h114,      32'h00000F0F};
        vt[6]  = '{OP_OR,   0, 2, 16'h8001, 32'h12340000, 32'd0,        32'h118,      32'h12348001};
        vt[7]  = '{OP_XOR,  0, 0, 16'h0,    32'hFFFF0000, 32'h0F0F0F0F, 32'h11C,      32'hF0F00F0F};
        vt[8]  = '{OP_SLL,  1, 0, 16'h0100, 32'hFFFFFFFF, 32'h000000F1, 32'h120,      32'h00000F10};
        vt[9]  = '{OP_SRL,  1, 0, 16'h07C0, 32'd0,        32'h80000000, 32'h124,      32'd1};
        vt[10] = '{OP_SRA,  1, 0, 16'h0100, 32'd0,        32'h80000000, 32'h128,      32'hF8000000};
        vt[11] = '{OP_LUI,  0, 1, 16'hABCD, 32'd0,        32'd0,        32'h12C,      32'hABCD0000};
        vt[12] = '{OP_ADD,  2, 3, 16'h0,    32'd0,        32'd0,        32'hBFC00010, 32'hBFC00018};
        vt[13] = '{OP_ADD,  0, 0, 16'h0,    32'hFFFFFFFF, 32'd2,        32'h130,      32'd1};

        resetn = 1'b1;
        ifc.ds_to_es_valid = 1'b0;
        ifc.ds_to_es_bus   = '0;
        ifc.ms_allowin     = 1'b1;
        m_hi = 32'h0; m_lo = 32'h0;
        #1 resetn = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst es_to_ms_valid", {31'b0, ifc.es_to_ms_valid}, 32'd0);
        check("rst es_valid_r",     {31'b0, ifc.es_valid_r},     32'd0);
        check("rst sram_en",        {31'b0, ifc.data_sram_en},   32'd0);
        check("rst sram_wen",       {28'b0, ifc.data_sram_wen},  32'd0);
        check("rst send_ready",     {31'b0, ifc.es_send_ready},  32'd0);
        check("rst es_allowin",     {31'b0, ifc.es_allowin},     32'd1);
        @(posedge clk); #1 resetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run(mk(vt[i].op, vt[i].s1, vt[i].s2, 1'b0, 1'b0, 1'b1, 5'(i + 1), vt[i].imm,
                   vt[i].rs, vt[i].rt, vt[i].pc), 0, ob, sr, fw, wc, ab);
            check($sformatf("vec%0d result", i), ob[63:32], vt[i].exp);
            check($sformatf("vec%0d pc", i), ob[31:0], vt[i].pc);
            check($sformatf("vec%0d dest", i), {27'b0, ob[68:64]}, 32'(i + 1));
            check($sformatf("vec%0d send_ready", i), {31'b0, sr}, 32'd1);
            check($sformatf("vec%0d fw_send", i), fw, vt[i].exp);
            check($sformatf("vec%0d latency", i), 32'(wc), 32'd0);
        end

        // lw accepted immediately, then lw held under a memory-stage stall
        ifc.ds_to_es_valid = 1'b1;
        ifc.ds_to_es_bus   = mk(OP_ADD, 0, 1, 1'b1, 1'b0, 1'b1, 5'd7, 16'd8, 32'h1000, 32'h0, 32'h200);
        ifc.ms_allowin     = 1'b1;
        @(posedge clk); #1 ifc.ds_to_es_valid = 1'b0;
        @(negedge clk);
        check("lw sram_en",     {31'b0, ifc.data_sram_en},        32'd1);
        check("lw sram_wen",    {28'b0, ifc.data_sram_wen},       32'd0);
        check("lw sram_addr",   ifc.data_sram_addr,               32'h1008);
        check("lw send_ready",  {31'b0, ifc.es_send_ready},       32'd0);
        check("lw res_from_mem", {31'b0, ifc.es_to_ms_bus[70]},   32'd1);
        check("lw es_to_ds_dest", {27'b0, ifc.es_to_ds_dest},     32'd7);
        check("lw es_we_r",     {31'b0, ifc.es_we_r},             32'd1);
        @(posedge clk); #1;
        ifc.ds_to_es_valid = 1'b1;
        ifc.ms_allowin     = 1'b0;
        @(posedge clk); #1 ifc.ds_to_es_valid = 1'b0;
        @(negedge clk);
        check("lw stall sram_en",  {31'b0, ifc.data_sram_en}, 32'd0);
        check("lw stall allowin",  {31'b0, ifc.es_allowin},   32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lw held valid", {31'b0, ifc.es_valid_r}, 32'd1);
        check("lw held addr",  ifc.data_sram_addr,      32'h1008);
        @(posedge clk); #1 ifc.ms_allowin = 1'b1;
        @(negedge clk);
        check("lw release sram_en", {31'b0, ifc.data_sram_en}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("lw gone", {31'b0, ifc.es_valid_r}, 32'd0);
        @(posedge clk); #1;

        // mult then mf*
        exec(OP_MULT, 0, 0, 16'h0, 32'hFFFFFFFD, 32'd7, 0, res);
        exec(OP_MFLO, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);
        check("mult lo", res, 32'hFFFFFFEB);
        exec(OP_MFHI, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);
        check("mult hi", res, 32'hFFFFFFFF);

        // signed divide and unsigned divide by zero
        exec(OP_DIV, 0, 0, 16'h0, 32'hFFFFFFF9, 32'd2, 0, res);
        exec(OP_MFLO, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);
        check("div lo", res, 32'hFFFFFFFD);
        exec(OP_MFHI, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);
        check("div hi", res, 32'hFFFFFFFF);
        exec(OP_DIVU, 0, 0, 16'h0, 32'd7, 32'd0, 0, res);
        exec(OP_MFLO, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);
        check("divu0 lo", res, 32'hFFFFFFFF);
        exec(OP_MFHI, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);
        check("divu0 hi", res, 32'd7);

        // asynchronous reset while the divider is busy
        ifc.ds_to_es_valid = 1'b1;
        ifc.ds_to_es_bus   = mk(OP_DIV, 0, 0, 1'b0, 1'b0, 1'b1, 5'd2, 16'h0, 32'hFFFFFF9C, 32'd7, 32'h300);
        @(posedge clk); #1 ifc.ds_to_es_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst es_valid_r", {31'b0, ifc.es_valid_r},     32'd0);
        check("midrst to_ms_valid", {31'b0, ifc.es_to_ms_valid}, 32'd0);
        check("midrst allowin",    {31'b0, ifc.es_allowin},     32'd1);
        @(posedge clk); #1 resetn = 1'b1;
        m_hi = 32'h0; m_lo = 32'h0;
        exec(OP_MFHI, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);
        check("midrst hi cleared", res, 32'h0);
        exec(OP_DIV, 0, 0, 16'h0, 32'd100, 32'd7, 0, res);
        exec(OP_MFLO, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);
        check("post-rst div lo", res, 32'd14);
        exec(OP_MFHI, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);
        check("post-rst div hi", res, 32'd2);

        // sw and mthi under a 0,0,1 memory-stage stall
        stall_seq(mk(OP_ADD, 0, 1, 1'b1, 1'b1, 1'b0, 5'd0, 16'd4, 32'h2000, 32'hDEADBEEF, 32'h400), hits, held);
        check("sw write cycles", 32'(hits), 32'd1);
        check("sw held cycles",  32'(held), 32'd3);
        stall_seq(mk(OP_MTHI, 0, 0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 32'hCAFE0001, 32'h0, 32'h404), hits, held);
        check("mthi held cycles", 32'(held), 32'd3);
        m_hi = 32'hCAFE0001;
        exec(OP_MFHI, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);
        check("mthi hi", res, 32'hCAFE0001);

        // randomized instruction stream against the model
        for (int i = 0; i < 80; i++) begin
            int pick;
            pick = $urandom_range(99);
            if (pick < 50)      op = $urandom_range(OP_LUI);
            else if (pick < 90) op = $urandom_range(OP_MFLO, OP_MULT);
            else                op = $urandom_range(OP_DIVU, OP_DIV);
            case ($urandom_range(3))
                0: rs = 32'h80000000;
                1: rs = 32'hFFFFFFFF;
                default: rs = $urandom;
            endcase
            case ($urandom_range(4))
                0: rt = 32'h0;
                1: rt = 32'hFFFFFFFF;
                default: rt = $urandom;
            endcase
            imm = 16'($urandom);
            s1 = (op <= OP_LUI) ? int'($urandom_range(2)) : 0;
            s2 = (op <= OP_LUI) ? int'($urandom_range(3)) : 0;
            exec(op, s1, s2, imm, rs, rt, 30, res);
        end
        exec(OP_MFHI, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);
        exec(OP_MFLO, 0, 0, 16'h0, 32'h0, 32'h0, 0, res);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
